// File: rtl/rl_fifo_1r1w_ctrl.sv
// First-word-fall-through FIFO controller wrapped around an external 1R1W RAM
// with 1-cycle read latency. The RAM's registered dout serves as the head word.
module rl_fifo_1r1w_ctrl #(
  parameter int ABITS      = 4,
  parameter int DBITS      = 32,
  parameter int AFULL_LVL  = 2**ABITS - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [DBITS-1:0]       d_i,
  input  logic                   pop_i,
  output logic [DBITS-1:0]       q_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic [ABITS:0]         count_o,
  output logic                   overflow_o,
  output logic                   underflow_o,
  output logic [ABITS-1:0]       ram_waddr_o,
  output logic [DBITS-1:0]       ram_din_o,
  output logic                   ram_we_o,
  output logic [(DBITS+7)/8-1:0] ram_be_o,
  output logic [ABITS-1:0]       ram_raddr_o,
  output logic                   ram_re_o,
  input  logic [DBITS-1:0]       ram_dout_i
);

  localparam int DEPTH = 2**ABITS;

  logic [ABITS-1:0] wptr;
  logic [ABITS-1:0] rptr;
  logic [ABITS:0]   ram_occ;
  logic             head_vld;
  logic             overflow_q;
  logic             underflow_q;
  logic             pop_ok;
  logic             push_ok;
  logic             read_en;

  // NOTE: every signal driven here gets a default at the top so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    count_o        = ram_occ + {{ABITS{1'b0}}, head_vld};
    full_o         = (count_o == (ABITS+1)'(DEPTH));
    empty_o        = ~head_vld;
    almost_full_o  = (int'(count_o) >= AFULL_LVL);
    almost_empty_o = (int'(count_o) <= AEMPTY_LVL);
    pop_ok         = pop_i & head_vld & ~clr_i;
    push_ok        = push_i & ~clr_i & (~full_o | pop_ok);
    // ram_occ excludes this cycle's push, so a read never targets the slot being written.
    read_en        = ~clr_i & (ram_occ != '0) & (~head_vld | pop_ok);
  end

  assign q_o         = ram_dout_i;
  assign ram_din_o   = d_i;
  assign ram_we_o    = push_ok;
  assign ram_waddr_o = wptr;
  assign ram_re_o    = read_en;
  assign ram_raddr_o = rptr;
  assign ram_be_o    = '1;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr        <= '0;
      rptr        <= '0;
      ram_occ     <= '0;
      head_vld    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clr_i) begin
      wptr        <= '0;
      rptr        <= '0;
      ram_occ     <= '0;
      head_vld    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + ABITS'(1);
      if (read_en) rptr <= rptr + ABITS'(1);
      ram_occ <= ram_occ + (ABITS+1)'(push_ok) - (ABITS+1)'(read_en);
      if (read_en)     head_vld <= 1'b1;
      else if (pop_ok) head_vld <= 1'b0;
      overflow_q  <= push_i & ~push_ok;
      underflow_q <= pop_i & ~head_vld;
    end
  end

endmodule

// File: tb/tb_rl_fifo_1r1w_ctrl.sv
// Directed bench for rl_fifo_1r1w_ctrl with a behavioural 1R1W RAM
// (registered dout that holds while re is low).
module tb_rl_fifo_1r1w_ctrl;

  localparam int ABITS = 2;
  localparam int DBITS = 8;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             clr;
  logic             push;
  logic [DBITS-1:0] d;
  logic             pop;
  logic [DBITS-1:0] q;
  logic             empty, full, afull, aempty, ovf, unf;
  logic [ABITS:0]   count;
  logic [ABITS-1:0] waddr, raddr;
  logic [DBITS-1:0] din;
  logic             we, re;
  logic [0:0]       be;
  logic [DBITS-1:0] dout = '0;
  logic [DBITS-1:0] mem [2**ABITS];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rl_fifo_1r1w_ctrl #(
    .ABITS(ABITS), .DBITS(DBITS), .AFULL_LVL(3), .AEMPTY_LVL(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr), .push_i(push), .d_i(d), .pop_i(pop),
    .q_o(q), .empty_o(empty), .full_o(full), .almost_full_o(afull),
    .almost_empty_o(aempty), .count_o(count), .overflow_o(ovf), .underflow_o(unf),
    .ram_waddr_o(waddr), .ram_din_o(din), .ram_we_o(we), .ram_be_o(be),
    .ram_raddr_o(raddr), .ram_re_o(re), .ram_dout_i(dout)
  );

  always @(posedge clk) begin
    if (we) mem[waddr] <= din;
    if (re) dout <= mem[raddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_push;
    int n_pop;
    logic [7:0] exp_q;
    rst_ni = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; d = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_aempty", aempty, 1);
    check("rst_afull", afull, 0);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);
    check("rst_we", we, 0);
    check("rst_re", re, 0);
    check("be_ones", be, 1);
    rst_ni = 1'b1;
    tick();

    // 1: single push, head appears one cycle after the accepting edge
    push = 1'b1; d = 8'hA1; #1;
    check("t1_we", we, 1);
    tick();
    push = 1'b0; #1;
    check("t1_empty_lat", empty, 1);
    check("t1_re", re, 1);
    tick();
    check("t1_empty", empty, 0);
    check("t1_q", q, 8'hA1);
    check("t1_count", count, 1);
    check("t1_aempty", aempty, 1);
    pop = 1'b1; tick(); pop = 1'b0;
    check("t1_drained", empty, 1);

    // 2: fill to full, then overflow
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; d = 8'h10 + 8'(i);
      tick();
      check("t2_count", count, i + 1);
      check("t2_afull", afull, (i >= 2) ? 1 : 0);
      check("t2_full", full, (i == 3) ? 1 : 0);
    end
    push = 1'b1; d = 8'h14; #1;
    check("t2_ovf_we", we, 0);
    tick();
    push = 1'b0;
    check("t2_ovf_pulse", ovf, 1);
    check("t2_ovf_count", count, 4);
    tick();
    check("t2_ovf_clear", ovf, 0);
    check("t2_head_kept", q, 8'h10);

    // 3: continuous pop drains in order at 1 word/cycle
    pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_empty", empty, 0);
      check("t3_q", q, 8'h10 + 8'(i));
      tick();
    end
    pop = 1'b0;
    check("t3_empty_end", empty, 1);
    check("t3_count_end", count, 0);
    check("t3_unf", unf, 0);

    // 4: push+pop together while full
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; d = 8'h10 + 8'(i); tick();
    end
    check("t4_full", full, 1);
    pop = 1'b1; d = 8'h20; #1;
    check("t4_q_before", q, 8'h10);
    check("t4_we", we, 1);
    tick();
    push = 1'b0;
    check("t4_count", count, 4);
    check("t4_ovf", ovf, 0);
    exp_q = 8'h11;
    for (int i = 0; i < 4; i++) begin
      check("t4_drain", q, (i == 3) ? 8'h20 : exp_q);
      exp_q = exp_q + 8'h01;
      tick();
    end
    pop = 1'b0;
    check("t4_empty", empty, 1);

    // 5: head-only push+pop bubble, then underflow
    push = 1'b1; d = 8'h30; tick(); push = 1'b0; tick();
    check("t5_q30", q, 8'h30);
    check("t5_count1", count, 1);
    push = 1'b1; pop = 1'b1; d = 8'h31; tick();
    push = 1'b0; pop = 1'b0;
    check("t5_bubble", empty, 1);
    check("t5_bubble_cnt", count, 1);
    tick();
    check("t5_after_bubble", empty, 0);
    check("t5_q31", q, 8'h31);
    pop = 1'b1; tick(); pop = 1'b0;
    check("t5_empty", empty, 1);
    pop = 1'b1; tick(); pop = 1'b0;
    check("t5_unf_pulse", unf, 1);
    check("t5_unf_count", count, 0);
    tick();
    check("t5_unf_clear", unf, 0);

    // 6: clear beats push, then stream across the pointer wrap
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; d = 8'h40 + 8'(i); tick();
    end
    check("t6_count3", count, 3);
    clr = 1'b1; push = 1'b1; d = 8'h43; #1;
    check("t6_clr_we", we, 0);
    check("t6_clr_re", re, 0);
    tick();
    clr = 1'b0; push = 1'b0;
    check("t6_clr_count", count, 0);
    check("t6_clr_empty", empty, 1);
    check("t6_clr_afull", afull, 0);
    check("t6_clr_ovf", ovf, 0);

    n_push = 0; n_pop = 0; exp_q = 8'h50;
    for (int cyc = 0; cyc < 40 && n_pop < 10; cyc++) begin
      pop  = ~empty;
      push = (n_push < 10);
      d    = 8'h50 + 8'(n_push);
      #1;
      if (pop) begin
        check("t6_order", q, exp_q);
        exp_q = exp_q + 8'h01;
        n_pop++;
      end
      if (we) n_push++;
      tick();
    end
    push = 1'b0; pop = 1'b0;
    check("t6_popped", n_pop, 10);
    check("t6_final_empty", empty, 1);
    check("t6_final_count", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
